// File: rtl/mdu_defs.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings and default latencies.
package mdu_defs;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } mdu_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_core.sv
// Combinational arithmetic for MULT/MULTU/DIV/DIVU, including divide-by-zero and
// signed-overflow results, split into the values destined for HI and LO.
module mdu_core
  import mdu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
  logic        [2*WIDTH-1:0] a_zx, b_zx, prod_u;
  logic signed [WIDTH-1:0]   a_s, b_s_safe, quot_s, rem_s;
  logic        [WIDTH-1:0]   b_u_safe, quot_u, rem_u;
  logic                      div_zero, div_ovf;

  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  assign div_zero = (b == '0);
  assign div_ovf  = (a == MOST_NEG) && (b == '1);

  // Divisors are forced to 1 in the special cases so the raw dividers never see
  // a zero or an overflowing operand; the special-case muxes below pick the result.
  assign a_s      = a;
  assign b_s_safe = (div_zero || div_ovf) ? ONE : b;
  assign b_u_safe = div_zero ? ONE : b;
  assign quot_s   = a_s / b_s_safe;
  assign rem_s    = a_s % b_s_safe;
  assign quot_u   = a / b_u_safe;
  assign rem_u    = a % b_u_safe;

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    case (op)
      OP_MULT:  {hi_res, lo_res} = prod_s;
      OP_MULTU: {hi_res, lo_res} = prod_u;
      OP_DIV: begin
        if (div_zero) begin
          lo_res = '1;
          hi_res = a;
        end else if (div_ovf) begin
          lo_res = MOST_NEG;
          hi_res = '0;
        end else begin
          lo_res = quot_s;
          hi_res = rem_s;
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          lo_res = '1;
          hi_res = a;
        end else begin
          lo_res = quot_u;
          hi_res = rem_u;
        end
      end
      default: begin
        hi_res = '0;
        lo_res = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with HI/LO registers: the result is computed at
// start, held in pending registers, and committed to HI/LO when the counter expires.
module mdu_hilo
  import mdu_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
  logic [WIDTH-1:0] hi_res, lo_res;

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .op     (op),
    .a      (a),
    .b      (b),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
    end
  end

  // Encodings 0..3 are the arithmetic ops; bit 1 separates divide from multiply.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    case (state_q)
      IDLE: begin
        if (en && !cancel) begin
          if (op[2] == 1'b0) begin
            state_d   = RUN;
            cnt_d     = op[1] ? DIV_LOAD : MULT_LOAD;
            hi_pend_d = hi_res;
            lo_pend_d = lo_res;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        if (cancel) begin
          state_d   = IDLE;
          cnt_d     = '0;
          hi_pend_d = '0;
          lo_pend_d = '0;
        end else if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = hi_pend_q;
          lo_d    = lo_pend_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign rd   = (op == OP_MFHI) ? hi_q : ((op == OP_MFLO) ? lo_q : '0);

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: stimulus pushes expected HI/LO and busy length,
// a monitor pops and compares each time busy falls.
module tb_mdu_hilo;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi, lo, rd;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  bit   skip_mon = 1'b0;
  int   busy_cnt = 0;
  bit   busy_prev = 1'b0;

  always #5 clk = ~clk;

  mdu_hilo #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .rd     (rd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a busy 1->0 transition marks the end of an operation.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      busy_cnt++;
    end else if (busy_prev) begin
      if (!skip_mon) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got busy fall with empty queue, required none");
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_hi"}, hi, e.hi);
          check({e.name, "_lo"}, lo, e.lo);
          check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.cycles));
        end
      end
      busy_cnt = 0;
    end
    busy_prev = (busy === 1'b1);
  end

  task automatic start_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(posedge clk); #1;
    en = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    en = 1'b0; op = OP_MFHI;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy === 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got busy=1 after 50 cycles, required 0", name);
    end
    @(negedge clk); #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input int cyc);
    exp_q.push_back('{name, eh, el, cyc});
    start_op(o, av, bv);
    wait_done(name);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; op = OP_MFHI; a = '0; b = '0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_rd", rd, 32'h0);
    reset = 1'b0;

    run_op("mult_neg1x2",  OP_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    run_op("multu_maxx2",  OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
    run_op("mult_mixed",   OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5);
    run_op("div_m7_2",     OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op("divu_by0",     OP_DIVU,  32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 10);
    run_op("div_ovf",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
    run_op("div_by0",      OP_DIV,   32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 10);

    // MTLO issued while a DIVU is in flight must be dropped.
    exp_q.push_back('{"divu_mt_busy", 32'd2, 32'd14, 10});
    start_op(OP_DIVU, 32'd100, 32'd7);
    en = 1'b1; op = OP_MTLO; a = 32'h1234;
    @(posedge clk); #1;
    en = 1'b0; op = OP_MFHI;
    wait_done("divu_mt_busy");

    // MTLO / MTHI when idle: one-edge latency, visible via rd.
    start_op(OP_MTLO, 32'h1234, 32'h0);
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_busy", {31'b0, busy}, 32'h0);
    op = OP_MFLO; #1;
    check("mflo_rd", rd, 32'h1234);
    start_op(OP_MTHI, 32'hABCD, 32'h0);
    op = OP_MFHI; #1;
    check("mfhi_rd", rd, 32'hABCD);
    op = OP_MULT; #1;
    check("rd_other_op", rd, 32'h0);
    op = OP_MFHI;

    // Cancel during busy cycle 3 of a DIV: hi/lo keep their previous contents.
    exp_q.push_back('{"div_cancel", 32'hABCD, 32'h1234, 3});
    start_op(OP_DIV, 32'd100, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    wait_done("div_cancel");

    // Cancel in the same cycle as a start or MT op drops the op.
    cancel = 1'b1;
    start_op(OP_MULT, 32'd3, 32'd3);
    check("cancel_start_busy", {31'b0, busy}, 32'h0);
    start_op(OP_MTLO, 32'h5555, 32'h0);
    cancel = 1'b0;
    check("cancel_mt_lo", lo, 32'h1234);
    check("cancel_start_hi", hi, 32'hABCD);

    // Back-to-back: second op starts in the first idle cycle.
    run_op("b2b_multu", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 5);
    run_op("b2b_divu",  OP_DIVU,  32'd42, 32'd5, 32'd2, 32'd8, 10);

    // Asynchronous reset in the middle of a MULT.
    skip_mon = 1'b1;
    start_op(OP_MULT, 32'd9, 32'd9);
    #12;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_commit_lo", lo, 32'h0);
    skip_mon = 1'b0;

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core generation. It replaces single-cycle ALU-only arithmetic. Operands arrive from the EX stage, and the result is committed to HI/LO after a configurable multi-cycle latency. `busy` drives the pipeline stall logic, and `cancel` lets exception flush abort an in-flight operation. MFHI/MFLO read data returns combinationally to the EX result mux.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width in bits; must be at least 2.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU; must be at least 1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  op strobe, sampled on the rising edge.
- op  in  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- a  in  WIDTH  rs operand; dividend for divides; source for MTHI/MTLO.
- b  in  WIDTH  rt operand; divisor for divides.
- cancel  in  1  abort the in-flight op and suppress any op strobed this cycle.
- busy  out  1  registered; high while an operation is in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rd  out  WIDTH  combinational: hi if op is MFHI, lo if op is MFLO, else 0. Does not depend on en.

## Operation
- Reset (asynchronous):
  - hi = 0, lo = 0, busy = 0, counter = 0.
  - Pending results cleared.
- Start:
  - Condition: en & MULT/MULTU/DIV/DIVU & !busy & !cancel.
  - Result is computed from a and b and latched into pending registers.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
- States: IDLE (counter = 0) and RUN (counter > 0). busy = RUN.
- RUN behaviour:
  - Each edge decrements the counter.
  - On the edge where counter = 1, pending values are written to hi/lo and the block returns to IDLE.
- Multiply (full 2·WIDTH-bit product):
  - MULT: signed × signed.
  - MULTU: unsigned × unsigned.
  - hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide:
  - lo = quotient, truncated toward zero.
  - hi = remainder, which carries the sign of the dividend (DIV).
- Divide by zero (DIV and DIVU): lo = all ones, hi = a.
- Signed overflow (DIV of the most-negative value by −1): lo = most-negative value, hi = 0.
- MTHI/MTLO:
  - Condition: en & !busy & !cancel.
  - Writes a into hi or lo on the edge.
- Ignored operations:
  - Any en while busy is ignored; no queueing. The pipeline must stall while busy.
  - MFHI/MFLO have no side effect.
- Cancel:
  - cancel while busy: counter is cleared and busy falls next edge. hi/lo keep their pre-op values and pending results are discarded.
  - cancel in the same cycle as a start or MT op: cancel wins and the op is dropped.
- rd during busy returns the old hi/lo. The consumer stalls MF* reads while busy is set.

## Timing
- Start sampled at edge t0: busy is high in cycles t0+1 … t0+N, where N is the op latency.
- hi/lo take the new value at edge t0+N; busy is 0 after that same edge.
- Back-to-back ops: a new op can start in the first cycle where busy = 0, giving a throughput of 1 op per N+1 edges.
- MTHI/MTLO latency: 1 edge, visible on hi/lo and rd the next cycle.
- Reset mid-operation: busy and hi/lo clear immediately (asynchronously), with no result commit.

## Structure
- Shared package/header `mdu_defs` holds:
  - Op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7.
  - Default latency constants.
- Sub-module `mdu_core`: combinational product and quotient/remainder for all four arithmetic ops, including the divide-by-zero and overflow rules.
- The top holds the counter, pending registers, hi/lo and the control logic.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES) + 1).

## Test plan
- MULT a=0xFFFFFFFF, b=2 → busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide edge cases:
  - DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTLO 0x1234 while busy → ignored.
- MTLO 0x1234 when idle → lo=0x1234 next cycle; rd with op=MFLO returns 0x1234.
- DIV started, cancel asserted in busy cycle 3 → busy falls next edge; hi/lo unchanged.
- Separately: reset asserted mid-MULT → hi=lo=0 and busy=0 immediately.
